// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite definitions used by the SRAM subordinate and its byte-mask helper.
package pkg_ahb;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Subordinate FSM; the state register is the single source of hreadyout/hresp.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_slv_state_e;

endpackage

// File: rtl/ahb_sram_bmask.sv
// Transfer size + low address bits to little-endian byte enables.
// Misaligned accesses are aligned down to the size boundary; sizes above a
// word are treated as a word, so the mask is always well defined.
module ahb_sram_bmask
    import pkg_ahb::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr,
    output logic [3:0] byte_en
);

    // Decode the lanes touched by the transfer.
    always_comb begin
        byte_en = 4'b1111;
        case (hsize)
            HSIZE_BYTE: byte_en = 4'b0001 << addr;
            HSIZE_HALF: byte_en = addr[1] ? 4'b1100 : 4'b0011;
            default:    byte_en = 4'b1111;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate in front of a word-organised SRAM with programmable
// wait states. Build option AHB_SRAM_ERR_EN enables the two-cycle ERROR
// response for out-of-range, oversize and misaligned transfers; without it
// addresses alias modulo MEM_BYTES and misaligned accesses are aligned down.
//
// Handshake: an address phase is taken at a posedge where hsel, htrans[1]
// and hready are all high; a data phase ends at the posedge where
// hreadyout is high. hreadyout/hresp/hrdata are pure functions of the
// registered state, so they are stable for the whole cycle.
module ahb_sram_slave
    import pkg_ahb::*;
#(
    parameter int WORD_SIZE   = 32,
    parameter int MEM_BYTES   = 4096,
    parameter int ADDR_LENGTH = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hsel,
    input  logic [ADDR_LENGTH-1:0] haddr,
    input  logic [1:0]             htrans,
    input  logic                   hwrite,
    input  logic [2:0]             hsize,
    input  logic [2:0]             hburst,
    input  logic [3:0]             hprot,
    input  logic [WORD_SIZE-1:0]   hwdata,
    input  logic                   hready,
    output logic                   hreadyout,
    output logic                   hresp,
    output logic [WORD_SIZE-1:0]   hrdata
);

    localparam int         AW        = $clog2(MEM_BYTES);
    localparam int         WORDS     = MEM_BYTES / (WORD_SIZE / 8);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    ahb_slv_state_e state, state_d, start_state;

    logic [3:0]    wait_cnt;
    logic          cnt_done;
    logic          accept;
    logic          take;
    logic          addr_err;
    logic [AW-1:0] lat_addr;
    logic          lat_write;
    logic [2:0]    lat_size;
    logic [3:0]    lat_be;
    logic [AW-3:0] lat_idx;

    logic [WORD_SIZE-1:0] mem [WORDS];

    // hburst/hprot are not used; every transfer is a single transfer.
    logic unused_ok;
    assign unused_ok = ^{hburst, hprot, htrans[0], haddr};

    assign accept   = hsel && htrans[1] && hready;
    assign take     = accept && (state == ST_IDLE || state == ST_DATA || state == ST_ERR2);
    assign cnt_done = (wait_cnt == WAIT_LAST);
    assign lat_idx  = lat_addr[AW-1:2];

`ifdef AHB_SRAM_ERR_EN
    // Classify the address phase currently on the bus.
    always_comb begin
        addr_err = 1'b0;
        if (haddr >= ADDR_LENGTH'(MEM_BYTES))         addr_err = 1'b1;
        if (hsize > HSIZE_WORD)                        addr_err = 1'b1;
        if (hsize == HSIZE_HALF && haddr[0])           addr_err = 1'b1;
        if (hsize == HSIZE_WORD && haddr[1:0] != 2'b0) addr_err = 1'b1;
    end
`else
    assign addr_err = 1'b0;
`endif

    // First data-phase state for an address phase taken this cycle.
    always_comb begin
        start_state = ST_DATA;
        if (addr_err)             start_state = ST_ERR1;
        else if (WAIT_STATES > 0) start_state = ST_WAIT;
    end

    // Next state and the response driven during the current data phase.
    always_comb begin
        state_d   = state;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state)
            ST_IDLE: begin
                if (accept) state_d = start_state;
            end
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (cnt_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                state_d = accept ? start_state : ST_IDLE;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                hresp   = HRESP_ERROR;
                state_d = accept ? start_state : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, wait counter and address-phase capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_size  <= HSIZE_BYTE;
        end else begin
            state <= state_d;
            if (state == ST_WAIT && !cnt_done) wait_cnt <= wait_cnt + 4'd1;
            else                               wait_cnt <= 4'd0;
            if (take) begin
                lat_addr  <= haddr[AW-1:0];
                lat_write <= hwrite;
                lat_size  <= hsize;
            end
        end
    end

    ahb_sram_bmask u_bmask (
        .hsize   (lat_size),
        .addr    (lat_addr[1:0]),
        .byte_en (lat_be)
    );

    // Commit write lanes at the posedge that ends a DATA cycle. An async reset
    // forces the state out of DATA first, so a pending write is dropped.
    always_ff @(posedge clk) begin
        if (state == ST_DATA && lat_write) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_be[b]) mem[lat_idx][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    // Full-word read data only during a read DATA cycle.
    assign hrdata = (state == ST_DATA && !lat_write) ? mem[lat_idx] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (WAIT_STATES=1 and 0) driven by a
// pipelined AHB master and checked against a byte-addressed memory model.
module tb_ahb_sram_slave;

  localparam int MEM_BYTES = 4096;

  logic        clk;
  logic        rst;
  logic        hsel_a      [2];
  logic [31:0] haddr_a     [2];
  logic [1:0]  htrans_a    [2];
  logic        hwrite_a    [2];
  logic [2:0]  hsize_a     [2];
  logic [2:0]  hburst_a    [2];
  logic [3:0]  hprot_a     [2];
  logic [31:0] hwdata_a    [2];
  logic        gate_a      [2];
  logic        hready_a    [2];
  logic        hreadyout_a [2];
  logic        hresp_a     [2];
  logic [31:0] hrdata_a    [2];

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          gap;
    logic        has_const;
    logic [31:0] cval;
  } tx_t;

  tx_t        txq[$];
  logic [7:0] mdl [2][MEM_BYTES];
  int         total = 0;
  int         bad   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign hready_a[g] = hreadyout_a[g] & gate_a[g];
    ahb_sram_slave #(
      .WORD_SIZE  (32),
      .MEM_BYTES  (MEM_BYTES),
      .ADDR_LENGTH(32),
      .WAIT_STATES((g == 0) ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .hsel     (hsel_a[g]),
      .haddr    (haddr_a[g]),
      .htrans   (htrans_a[g]),
      .hwrite   (hwrite_a[g]),
      .hsize    (hsize_a[g]),
      .hburst   (hburst_a[g]),
      .hprot    (hprot_a[g]),
      .hwdata   (hwdata_a[g]),
      .hready   (hready_a[g]),
      .hreadyout(hreadyout_a[g]),
      .hresp    (hresp_a[g]),
      .hrdata   (hrdata_a[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  function automatic int ws_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic bit is_err(input logic [31:0] addr, input logic [2:0] size);
    bit e;
    e = (addr >= MEM_BYTES) || (size > 3'd2) ||
        (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
`ifndef AHB_SRAM_ERR_EN
    e = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [31:0] mdl_read(input int i, input logic [31:0] addr);
    int a;
    a = int'(addr % MEM_BYTES) & ~3;
    return {mdl[i][a+3], mdl[i][a+2], mdl[i][a+1], mdl[i][a]};
  endfunction

  task automatic mdl_write(input int i, input logic [31:0] addr, input logic [2:0] size,
                           input logic [31:0] data);
    int n;
    int base;
    int b;
    n    = 1 << ((size > 3'd2) ? 2 : int'(size));
    base = int'(addr % MEM_BYTES) & ~(n - 1);
    for (int k = 0; k < n; k++) begin
      b = base + k;
      mdl[i][b] = data[8*(b%4) +: 8];
    end
  endtask

  // driver tasks
  task automatic drive_idle(input int i);
    hsel_a[i]   = 1'($urandom_range(0, 1));
    htrans_a[i] = 2'($urandom_range(0, 1));
    haddr_a[i]  = $urandom;
    hwrite_a[i] = 1'($urandom_range(0, 1));
    hsize_a[i]  = 3'd2;
  endtask

  task automatic drive_decoy(input int i);
    hsel_a[i]   = 1'b0;
    htrans_a[i] = 2'b10;
    haddr_a[i]  = 32'($urandom_range(0, 511));
    hwrite_a[i] = 1'b1;
    hsize_a[i]  = 3'd2;
  endtask

  task automatic drive_ap(input int i, input tx_t t);
    hsel_a[i]   = 1'b1;
    htrans_a[i] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
    haddr_a[i]  = t.addr;
    hwrite_a[i] = t.wr;
    hsize_a[i]  = t.size;
    hburst_a[i] = 3'($urandom_range(0, 7));
    hprot_a[i]  = 4'($urandom_range(0, 15));
  endtask

  function automatic tx_t mk(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                             input logic [31:0] wdata, input logic has_c, input logic [31:0] cval);
    tx_t t;
    t.addr = addr; t.wr = wr; t.size = size; t.wdata = wdata;
    t.gap = 0; t.has_const = has_c; t.cval = cval;
    return t;
  endfunction

  // Runs every queued transfer on instance i, pipelined, scoring each data phase.
  task automatic run_txs(input int i);
    tx_t ap;
    tx_t dp;
    tx_t t;
    bit  ap_v = 1'b0;
    bit  dp_v = 1'b0;
    bit  adv;
    bit  e;
    int  waits = 0;
    int  cyc = 0;
    logic [31:0] exp;
    ap = mk(0, 0, 0, 0, 0, 0);
    dp = ap;
    while ((ap_v || dp_v || txq.size() > 0) && cyc < 20000) begin
      cyc++;
      @(negedge clk);
      adv = hreadyout_a[i];
      if (dp_v) begin
        e = is_err(dp.addr, dp.size);
        if (!hreadyout_a[i]) begin
          waits++;
          check("wait_resp", 32'(hresp_a[i]), 32'(e));
          check("wait_rdata", hrdata_a[i], 32'h0);
        end else begin
          check("resp", 32'(hresp_a[i]), 32'(e));
          check("waits", 32'(waits), e ? 32'd1 : 32'(ws_of(i)));
          if (!e && !dp.wr) begin
            exp = dp.has_const ? dp.cval : mdl_read(i, dp.addr);
            check("rdata", hrdata_a[i], exp);
          end else begin
            check("rdata_zero", hrdata_a[i], 32'h0);
          end
          if (!e && dp.wr) mdl_write(i, dp.addr, dp.size, dp.wdata);
        end
      end else begin
        check("idle_rdy", 32'(hreadyout_a[i]), 32'd1);
        check("idle_resp", 32'(hresp_a[i]), 32'd0);
        check("idle_rdata", hrdata_a[i], 32'h0);
      end
      @(posedge clk);
      #1;
      if (adv) begin
        dp_v  = ap_v;
        dp    = ap;
        waits = 0;
        ap_v  = 1'b0;
        if (txq.size() > 0) begin
          t = txq[0];
          if (t.gap > 0) begin
            t.gap--;
            txq[0] = t;
            drive_decoy(i);
          end else begin
            ap   = txq.pop_front();
            ap_v = 1'b1;
            drive_ap(i, ap);
          end
        end else begin
          drive_idle(i);
        end
        hwdata_a[i] = (dp_v && dp.wr) ? dp.wdata : $urandom;
      end
    end
    if (ap_v || dp_v || txq.size() > 0) begin
      check("timeout", 32'd1, 32'd0);
      txq.delete();
      drive_idle(i);
    end
  endtask

  task automatic push_random(input int n);
    tx_t t;
    int  r;
    int  nb;
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(0, 5);
      t.size = (r < 2) ? 3'(r) : ((r == 5) ? 3'd3 : 3'd2);
      t.addr = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 9) == 0) t.addr = t.addr + MEM_BYTES;
      nb = (t.size > 3'd2) ? 4 : (1 << t.size);
      if ($urandom_range(0, 3) != 0) t.addr = t.addr & ~32'(nb - 1);
      t.wr = 1'($urandom_range(0, 1));
      t.wdata = $urandom;
      t.gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      t.has_const = 1'b0;
      t.cval = 32'h0;
      txq.push_back(t);
    end
  endtask

  // stimulus
  initial begin
    begin : watchdog
      fork
        begin
          #2000000;
          $display("FAIL watchdog expired");
          bad++;
          $display("test done: total=%0d bad=%0d", total, bad);
          $finish;
        end
      join_none
    end

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      gate_a[i] = 1'b1;
      hburst_a[i] = 3'd0;
      hprot_a[i] = 4'd0;
      hwdata_a[i] = 32'h0;
      drive_idle(i);
      hsel_a[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_rdy", 32'(hreadyout_a[i]), 32'd1);
      check("rst_resp", 32'(hresp_a[i]), 32'd0);
      check("rst_rdata", hrdata_a[i], 32'h0);
    end
    rst = 1'b0;

    for (int i = 0; i < 2; i++) begin
      // known contents for the low 512 bytes
      for (int w = 0; w < 128; w++) txq.push_back(mk(32'(w * 4), 1'b1, 3'd2, $urandom, 1'b0, 32'h0));
      run_txs(i);

      txq.push_back(mk(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0));
      txq.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0, 1'b1, 32'hDEADBEEF));
      txq.push_back(mk(32'h10, 1'b1, 3'd2, 32'h11223344, 1'b0, 32'h0));
      txq.push_back(mk(32'h13, 1'b1, 3'd0, 32'hAAAAAAAA, 1'b0, 32'h0));
      txq.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0, 1'b1, 32'hAA223344));
      txq.push_back(mk(32'h20, 1'b1, 3'd2, 32'h0, 1'b0, 32'h0));
      txq.push_back(mk(32'h22, 1'b1, 3'd1, 32'hBEEFBEEF, 1'b0, 32'h0));
      txq.push_back(mk(32'h20, 1'b0, 3'd2, 32'h0, 1'b1, 32'hBEEF0000));
      txq.push_back(mk(32'h40, 1'b1, 3'd2, 32'h1, 1'b0, 32'h0));
      txq.push_back(mk(32'h40, 1'b0, 3'd2, 32'h0, 1'b1, 32'h00000001));
      txq.push_back(mk(32'h08, 1'b1, 3'd2, 32'hA5A5A5A5, 1'b0, 32'h0));
      txq.push_back(mk(32'h1000, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0));
      txq.push_back(mk(32'h2, 1'b1, 3'd2, 32'h12345678, 1'b0, 32'h0));
      txq.push_back(mk(32'h0, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0));
      run_txs(i);
    end

    // reset during the wait cycle of a write on the WAIT_STATES=1 instance
    @(posedge clk);
    #1;
    drive_ap(0, mk(32'h8, 1'b1, 3'd2, 32'h55, 1'b0, 32'h0));
    @(posedge clk);
    #1;
    drive_idle(0);
    hwdata_a[0] = 32'h55;
    check("rst_mid_wait", 32'(hreadyout_a[0]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_rdy", 32'(hreadyout_a[0]), 32'd1);
    check("rst_mid_resp", 32'(hresp_a[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txq.push_back(mk(32'h8, 1'b0, 3'd2, 32'h0, 1'b1, 32'hA5A5A5A5));
    run_txs(0);

    // address phase with hready low must be ignored
    @(posedge clk);
    #1;
    gate_a[0] = 1'b0;
    drive_ap(0, mk(32'h30, 1'b1, 3'd2, 32'h0, 1'b0, 32'h0));
    hwdata_a[0] = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    drive_idle(0);
    gate_a[0] = 1'b1;
    @(negedge clk);
    check("hready_low_rdy", 32'(hreadyout_a[0]), 32'd1);
    txq.push_back(mk(32'h30, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0));
    run_txs(0);

    for (int i = 0; i < 2; i++) begin
      push_random(80);
      run_txs(i);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite subordinate that fronts a word-organised on-chip SRAM model and acts as the memory behind the dcache AHB master.
- Accepts pipelined single transfers and inserts a programmable number of wait states.
- Performs byte, halfword and word writes through byte lanes.
- Always returns full-word read data.
- Used as the backing store in block-level and top-level dcache benches, and as the synthesizable scratch memory in the tile.

Parameters:
- WORD_SIZE, 32: data bus width in bits; only 32 is supported.
- MEM_BYTES, 4096: memory size in bytes; must be a power of two and a multiple of WORD_SIZE/8.
- ADDR_LENGTH, 32: HADDR width.
- WAIT_STATES, 1: wait cycles inserted per NONSEQ/SEQ data phase; legal range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- hsel  in  1  slave select.
- haddr  in  ADDR_LENGTH  address-phase address.
- htrans  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size: 0 byte, 1 half, 2 word.
- hburst  in  3  ignored; every transfer is treated as a single transfer.
- hprot  in  4  ignored.
- hwdata  in  WORD_SIZE  write data, valid in the data phase.
- hready  in  1  bus HREADY (HREADYIN); the address phase is valid only when high.
- hreadyout  out  1  0 = extend the current data phase.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  WORD_SIZE  read data, valid when hreadyout=1 in a read data phase.

Behaviour:
- Reset values: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- Address phase accept: at a posedge with hsel && htrans[1] && hready, latch haddr, hwrite, hsize and the error flag, then enter the data phase.
- IDLE/BUSY/unselected transfers: zero-wait OKAY response; nothing is latched.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE, accept, error flag=0: go to WAIT if WAIT_STATES>0, else DATA.
  - IDLE, accept, error flag=1: go to ERR1.
  - WAIT: hreadyout=0, hresp=0. The counter counts up to WAIT_STATES-1, then the FSM goes to DATA.
  - DATA: hreadyout=1, hresp=0.
    - Read: hrdata = mem[latched word index], driven combinationally.
    - Write: commit hwdata lanes at the posedge ending DATA.
    - Exit: a new accept in the same cycle (pipelined) goes straight to WAIT/DATA/ERR1; otherwise go to IDLE.
  - ERR1: hreadyout=0, hresp=1. Next state is ERR2.
  - ERR2: hreadyout=1, hresp=1. No memory write. Exit follows the same rules as DATA.
- Word index = latched addr[$clog2(MEM_BYTES)-1:2].
- Byte lanes are little-endian, lane = addr[1:0].
  - Byte write: lane addr[1:0].
  - Halfword write: lanes {addr[1],0} and {addr[1],1}.
  - Word write: all 4 lanes.
- hrdata is 0 outside a read DATA cycle.
- Read-after-write: a read whose address phase overlaps a write data phase to the same word returns the new data, because the write commits before the read's DATA cycle.
- Error flag, when AHB_SRAM_ERR_EN is defined, is set by any of:
  - haddr >= MEM_BYTES;
  - hsize > 2;
  - misalignment: half with haddr[0]=1, or word with haddr[1:0]!=0.
- Reset asserted mid-transfer: the transfer is abandoned, outputs return to reset values, and a pending write is not committed.
- An address phase is never accepted while hready=0, even if hsel and htrans are valid.

Optional Feature:
- Macro AHB_SRAM_ERR_EN.
  - Defined: error detection and the two-cycle ERROR response are as above.
  - Undefined: no errors; hresp is tied 0 and ERR1/ERR2 are unreachable.
    - Out-of-range addresses alias modulo MEM_BYTES.
    - Misaligned accesses are aligned down to the hsize boundary.
    - hsize > 2 is treated as a word access.

Decomposition:
- Shared package pkg_ahb:
  - htrans_e (IDLE, BUSY, NONSEQ, SEQ);
  - hsize constants HSIZE_BYTE/HALF/WORD;
  - HRESP_OKAY/HRESP_ERROR;
  - FSM state enum ahb_slv_state_e.
- Sub-module ahb_sram_bmask: combinational hsize + addr[1:0] to 4-bit byte-enable (aligned-down behaviour included). It is reused by the dcache write path later.

Test Plan:
- Reset then WAIT_STATES=1, word write 0x0000_0010 = 0xDEADBEEF, then read 0x10:
  - each data phase has hreadyout=0 for 1 cycle, then 1;
  - read returns 0xDEADBEEF, hresp=0.
- Byte write 0xAA to 0x13 over prior word 0x11223344, then word read 0x10: returns 0xAA223344.
- Halfword write 0xBEEF to 0x22 over 0, then word read 0x20: returns 0xBEEF0000.
- WAIT_STATES=0, back-to-back pipelined write 0x40=0x1, then read 0x40:
  - no wait cycles;
  - read returns 0x00000001 in the cycle after the write data phase.
- With AHB_SRAM_ERR_EN defined:
  - word read 0x1000 gives hreadyout 0 then 1 with hresp=1 both cycles;
  - word write 0x0002 gives the same response, and memory is unchanged (read 0x0 returns its old value).
  - Without the macro, read 0x1000 returns the contents of 0x0 with OKAY.
- Assert rst during the WAIT cycle of a write of 0x55 to 0x8: hreadyout=1 and hresp=0 immediately, and a later read of 0x8 returns the pre-write value.
